// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the MIPS core: decoded control bundle and
// well-known register indices.
package mips_pipe_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection against the EX-side slot, and the upstream
// stall request combining it with the external hold.
module hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_dest,
  input  logic          flush,
  input  logic          hold,
  output logic          lu,
  output logic          stall_if_id
);

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_ex_is_load;

  assign w_ex_is_load = ex_valid && ex_mem_read && (ex_dest != AW'(REG_ZERO));
  assign w_rs_hit     = id_uses_rs && (id_rs == ex_dest);
  assign w_rt_hit     = id_uses_rt && (id_rt == ex_dest);
  assign lu           = id_valid && w_ex_is_load && (w_rs_hit || w_rt_hit);

  // A taken branch kills the stalled instruction, so there is nothing to hold.
  assign stall_if_id  = !rst && (hold || (lu && !flush));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass, load-use bubble
// insertion, branch flush and external hold.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int RA_IDX = REG_RA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [AW-1:0] id_dest,
  input  ctrl_t         id_ctrl,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] rf_rd_data0,
  input  logic [DW-1:0] rf_rd_data1,
  input  logic          wb_wr_en,
  input  logic          wb_jal,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  input  logic          hold,
  output logic          stall_if_id,
  output logic          ex_valid,
  output logic [DW-1:0] ex_rs_val,
  output logic [DW-1:0] ex_rt_val,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_dest,
  output ctrl_t         ex_ctrl,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4
);

  logic          r_ex_valid;
  logic [DW-1:0] r_ex_rs_val;
  logic [DW-1:0] r_ex_rt_val;
  logic [AW-1:0] r_ex_rs;
  logic [AW-1:0] r_ex_rt;
  logic [AW-1:0] r_ex_dest;
  ctrl_t         r_ex_ctrl;
  logic [DW-1:0] r_ex_imm;
  logic [DW-1:0] r_ex_pc4;

  logic [AW-1:0] w_wb_tgt;
  logic          w_wb_live;
  logic          w_byp0;
  logic          w_byp1;
  logic [DW-1:0] w_op0;
  logic [DW-1:0] w_op1;
  logic          w_lu;

  // The register file writes on the edge but reads combinationally, so a
  // same-cycle WB write must be forwarded into the captured operands.
  assign w_wb_tgt  = wb_jal ? AW'(RA_IDX) : wb_addr;
  assign w_wb_live = wb_wr_en && (w_wb_tgt != AW'(REG_ZERO));
  assign w_byp0    = w_wb_live && (w_wb_tgt == id_rs);
  assign w_byp1    = w_wb_live && (w_wb_tgt == id_rt);
  assign w_op0     = w_byp0 ? wb_data : rf_rd_data0;
  assign w_op1     = w_byp1 ? wb_data : rf_rd_data1;

  hazard_unit #(
    .AW(AW)
  ) u_hazard (
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (r_ex_valid),
    .ex_mem_read (r_ex_ctrl.mem_read),
    .ex_dest     (r_ex_dest),
    .flush       (flush),
    .hold        (hold),
    .lu          (w_lu),
    .stall_if_id (stall_if_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_rs_val <= '0;
      r_ex_rt_val <= '0;
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_dest   <= '0;
      r_ex_ctrl   <= CTRL_NOP;
      r_ex_imm    <= '0;
      r_ex_pc4    <= '0;
    end else if (!hold) begin
      // Data fields load unconditionally; only valid/ctrl decide whether a
      // bubble is inserted, which keeps every killed slot write-free.
      r_ex_rs_val <= w_op0;
      r_ex_rt_val <= w_op1;
      r_ex_rs     <= id_rs;
      r_ex_rt     <= id_rt;
      r_ex_dest   <= id_dest;
      r_ex_imm    <= id_imm;
      r_ex_pc4    <= id_pc4;
      if (flush || w_lu) begin
        r_ex_valid <= 1'b0;
        r_ex_ctrl  <= CTRL_NOP;
      end else begin
        r_ex_valid <= id_valid;
        r_ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
      end
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_rs_val = r_ex_rs_val;
  assign ex_rt_val = r_ex_rt_val;
  assign ex_rs     = r_ex_rs;
  assign ex_rt     = r_ex_rt;
  assign ex_dest   = r_ex_dest;
  assign ex_ctrl   = r_ex_ctrl;
  assign ex_imm    = r_ex_imm;
  assign ex_pc4    = r_ex_pc4;

endmodule
